// File: rtl/w_port_alloc_ctrl.sv
// ============================================================================
// Module   : w_port_alloc_ctrl
// Purpose  : West output-port allocation controller: credit tracking,
//            wormhole lock, FIFO pops, crossbar select, RR rotate strobe.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module w_port_alloc_ctrl #(
    parameter int CREDITS = 4,
    parameter int CW      = $clog2(CREDITS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          grant_n_i,
    input  logic          grant_s_i,
    input  logic          grant_e_i,
    input  logic          grant_l_i,
    input  logic          valid_n_i,
    input  logic          valid_s_i,
    input  logic          valid_e_i,
    input  logic          valid_l_i,
    input  logic          tail_n_i,
    input  logic          tail_s_i,
    input  logic          tail_e_i,
    input  logic          tail_l_i,
    input  logic          credit_return_i,
    output logic          downstream_credit_o,
    output logic          change_order_o,
    output logic [2:0]    xbar_sel_o,
    output logic          flit_send_o,
    output logic          pop_n_o,
    output logic          pop_s_o,
    output logic          pop_e_o,
    output logic          pop_l_o,
    output logic          locked_o,
    output logic          credit_err_o
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Input index: N=0, S=1, E=2, L=3
    localparam logic [1:0]    c_IDX_N      = 2'd0;
    localparam logic [1:0]    c_IDX_S      = 2'd1;
    localparam logic [1:0]    c_IDX_E      = 2'd2;
    localparam logic [1:0]    c_IDX_L      = 2'd3;
    localparam logic [2:0]    c_SEL_N      = 3'b000;
    localparam logic [2:0]    c_SEL_S      = 3'b001;
    localparam logic [2:0]    c_SEL_W      = 3'b010;
    localparam logic [2:0]    c_SEL_E      = 3'b011;
    localparam logic [2:0]    c_SEL_L      = 3'b100;
    localparam logic [CW-1:0] c_CREDIT_MAX = CW'(CREDITS);

    state_t          state_q, state_d;
    logic [1:0]      owner_q, owner_d;
    logic [CW-1:0]   credit_q, credit_d;
    logic            change_q, change_d;
    logic            err_q, err_d;

    logic [3:0]      w_valid;
    logic [3:0]      w_tail;
    logic [3:0]      w_pop;
    logic [1:0]      w_gidx;
    logic [1:0]      w_src;
    logic            w_any_grant;
    logic            w_has_credit;
    logic            w_send;
    logic [2:0]      w_xbar;

    function automatic logic [2:0] f_enc(input logic [1:0] idx);
        logic [2:0] sel;
        case (idx)
            c_IDX_N: sel = c_SEL_N;
            c_IDX_S: sel = c_SEL_S;
            c_IDX_E: sel = c_SEL_E;
            default: sel = c_SEL_L;
        endcase
        return sel;
    endfunction

    assign w_valid      = {valid_l_i, valid_e_i, valid_s_i, valid_n_i};
    assign w_tail       = {tail_l_i, tail_e_i, tail_s_i, tail_n_i};
    assign w_has_credit = (credit_q != '0);

    // Fixed priority N>S>E>L in case the grant is not one-hot
    always_comb begin
        w_any_grant = 1'b1;
        w_gidx      = c_IDX_N;
        if (grant_n_i)      w_gidx = c_IDX_N;
        else if (grant_s_i) w_gidx = c_IDX_S;
        else if (grant_e_i) w_gidx = c_IDX_E;
        else if (grant_l_i) w_gidx = c_IDX_L;
        else                w_any_grant = 1'b0;
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        change_d = 1'b0;
        w_send   = 1'b0;
        w_src    = owner_q;
        w_xbar   = c_SEL_W;
        case (state_q)
            ST_IDLE: begin
                if (w_any_grant && w_valid[w_gidx] && w_has_credit) begin
                    w_send = 1'b1;
                    w_src  = w_gidx;
                    w_xbar = f_enc(w_gidx);
                    if (w_tail[w_gidx]) begin
                        change_d = 1'b1;
                    end else begin
                        state_d = ST_LOCKED;
                        owner_d = w_gidx;
                    end
                end
            end
            ST_LOCKED: begin
                w_xbar = f_enc(owner_q);
                if (w_valid[owner_q] && w_has_credit) begin
                    w_send = 1'b1;
                    if (w_tail[owner_q]) begin
                        state_d  = ST_IDLE;
                        owner_d  = c_IDX_N;
                        change_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = c_IDX_N;
            end
        endcase
    end

    assign w_pop = w_send ? (4'b0001 << w_src) : 4'b0000;

    // Simultaneous send and return cancel; a return at the ceiling is an error
    always_comb begin
        credit_d = credit_q;
        err_d    = err_q;
        if (w_send && !credit_return_i) begin
            credit_d = credit_q - CW'(1);
        end else if (!w_send && credit_return_i) begin
            if (credit_q == c_CREDIT_MAX) err_d = 1'b1;
            else                          credit_d = credit_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            owner_q  <= c_IDX_N;
            credit_q <= c_CREDIT_MAX;
            change_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            credit_q <= credit_d;
            change_q <= change_d;
            err_q    <= err_d;
        end
    end

    assign pop_n_o             = w_pop[0];
    assign pop_s_o             = w_pop[1];
    assign pop_e_o             = w_pop[2];
    assign pop_l_o             = w_pop[3];
    assign flit_send_o         = w_send;
    assign xbar_sel_o          = w_xbar;
    assign locked_o            = (state_q == ST_LOCKED);
    assign change_order_o      = change_q;
    assign credit_err_o        = err_q;
    assign downstream_credit_o = w_has_credit;

endmodule

`default_nettype wire

// File: tb/tb_w_port_alloc_ctrl.sv
// ============================================================================
// Module   : tb_w_port_alloc_ctrl
// Purpose  : Directed table-driven bench for w_port_alloc_ctrl.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_w_port_alloc_ctrl;

    logic       clk;
    logic       reset;
    logic [3:0] g, v, t;
    logic       ret;
    logic       dc, co, snd, lk, err;
    logic [2:0] xs;
    logic       pn, ps, pe, pl;

    int checks;
    int errors;

    // Bit order in vectors: [3]=N [2]=S [1]=E [0]=L
    w_port_alloc_ctrl #(.CREDITS(4)) dut (
        .clk                 (clk),
        .reset               (reset),
        .grant_n_i           (g[3]),
        .grant_s_i           (g[2]),
        .grant_e_i           (g[1]),
        .grant_l_i           (g[0]),
        .valid_n_i           (v[3]),
        .valid_s_i           (v[2]),
        .valid_e_i           (v[1]),
        .valid_l_i           (v[0]),
        .tail_n_i            (t[3]),
        .tail_s_i            (t[2]),
        .tail_e_i            (t[1]),
        .tail_l_i            (t[0]),
        .credit_return_i     (ret),
        .downstream_credit_o (dc),
        .change_order_o      (co),
        .xbar_sel_o          (xs),
        .flit_send_o         (snd),
        .pop_n_o             (pn),
        .pop_s_o             (ps),
        .pop_e_o             (pe),
        .pop_l_o             (pl),
        .locked_o            (lk),
        .credit_err_o        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] g, v, t;
        logic       ret;
        logic [3:0] pop;
        logic [2:0] xs;
        logic       snd, lk, co, dc, err;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs sampled 3 units later.
    task automatic drive(input logic [3:0] gg, input logic [3:0] vv, input logic [3:0] tt, input logic rr);
        g = gg; v = vv; t = tt; ret = rr;
        #3;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        g = 4'b0; v = 4'b0; t = 4'b0; ret = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        //               g        v        t        ret   pop      xs      snd   lk    co    dc    err
        vecs[0]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{4'b0010, 4'b0010, 4'b0010, 1'b0, 4'b0010, 3'b011, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{4'b1010, 4'b1010, 4'b1010, 1'b0, 4'b1000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{4'b0100, 4'b0100, 4'b0100, 1'b0, 4'b0100, 3'b001, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{4'b0001, 4'b0001, 4'b0001, 1'b1, 4'b0001, 3'b100, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{4'b1000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{4'b0010, 4'b0010, 4'b0010, 1'b1, 4'b0010, 3'b011, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[13] = '{4'b1000, 4'b1000, 4'b0000, 1'b0, 4'b1000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[14] = '{4'b0100, 4'b0100, 4'b0000, 1'b0, 4'b0000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[15] = '{4'b0100, 4'b1100, 4'b0000, 1'b0, 4'b1000, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[16] = '{4'b0100, 4'b1100, 4'b1000, 1'b0, 4'b1000, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[17] = '{4'b0100, 4'b0000, 4'b0000, 1'b0, 4'b0000, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[18] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        do_reset();
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].g, vecs[i].v, vecs[i].t, vecs[i].ret);
            chk("pop",   i, {28'd0, pn, ps, pe, pl}, {28'd0, vecs[i].pop});
            chk("xbar",  i, {29'd0, xs},             {29'd0, vecs[i].xs});
            chk("send",  i, {31'd0, snd},            {31'd0, vecs[i].snd});
            chk("lock",  i, {31'd0, lk},             {31'd0, vecs[i].lk});
            chk("chord", i, {31'd0, co},             {31'd0, vecs[i].co});
            chk("dcred", i, {31'd0, dc},             {31'd0, vecs[i].dc});
            chk("cerr",  i, {31'd0, err},            {31'd0, vecs[i].err});
            next_cycle();
        end

        // Credit exhaustion: 6-flit packet on L with 4 credits
        do_reset();
        chk("rst_err", 0, {31'd0, err}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            drive(4'b0001, 4'b0001, 4'b0000, 1'b0);
            chk("exh_send", k, {31'd0, pl}, 32'd1);
            chk("exh_xbar", k, {29'd0, xs}, 32'd4);
            next_cycle();
        end
        for (int k = 0; k < 3; k++) begin
            drive(4'b0001, 4'b0001, 4'b0000, 1'b0);
            chk("stall_dc",   k, {31'd0, dc},  32'd0);
            chk("stall_send", k, {31'd0, snd}, 32'd0);
            chk("stall_lock", k, {31'd0, lk},  32'd1);
            next_cycle();
        end
        drive(4'b0001, 4'b0001, 4'b0000, 1'b1);
        chk("ret_cycle_send", 0, {31'd0, snd}, 32'd0);
        next_cycle();
        drive(4'b0001, 4'b0001, 4'b0000, 1'b0);
        chk("one_more_send", 0, {31'd0, pl}, 32'd1);
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            drive(4'b0001, 4'b0001, 4'b0001, 1'b0);
            chk("after_send", k, {31'd0, snd}, 32'd0);
            next_cycle();
        end

        // Reset while locked on S mid-packet
        do_reset();
        drive(4'b0100, 4'b0100, 4'b0000, 1'b0);
        chk("s_head", 0, {31'd0, ps}, 32'd1);
        next_cycle();
        drive(4'b0000, 4'b0100, 4'b0000, 1'b0);
        chk("s_body", 0, {31'd0, ps}, 32'd1);
        chk("s_lock", 0, {31'd0, lk}, 32'd1);
        chk("s_xbar", 0, {29'd0, xs}, 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_lock", 0, {31'd0, lk},  32'd0);
        chk("mid_rst_xbar", 0, {29'd0, xs},  32'd2);
        chk("mid_rst_send", 0, {31'd0, snd}, 32'd0);
        chk("mid_rst_dc",   0, {31'd0, dc},  32'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        drive(4'b0000, 4'b0100, 4'b0000, 1'b0);
        chk("no_grant_pop", 0, {31'd0, ps}, 32'd0);
        next_cycle();
        // Full credit after reset: four single-flit sends, then stall
        for (int k = 0; k < 5; k++) begin
            drive(4'b0001, 4'b0001, 4'b0001, 1'b0);
            chk("full_cred", k, {31'd0, snd}, (k < 4) ? 32'd1 : 32'd0);
            next_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
